frame_grabber: RTL and testbench

FRAME_GRABBER -- requirements
Module: frame_grabber

---
 rtl/frame_grabber_pkg.sv | 30 +++
 rtl/frame_grabber_sync_fifo.sv | 54 +++++
 rtl/frame_grabber.sv | 146 ++++++++++++++
 tb/tb_frame_grabber.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_grabber_pkg.sv
// Shared types and register map for the frame grabber.
package frame_grabber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_LIMIT  = 2'd3;

  localparam int unsigned CTRL_ARM       = 0;
  localparam int unsigned CTRL_ABORT     = 1;
  localparam int unsigned CTRL_ACK       = 2;
  localparam int unsigned CTRL_IRQ_EN    = 3;
  localparam int unsigned CTRL_DECIM_LSB = 4;

  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_UDF       = 3;
  localparam int unsigned STAT_EMPTY     = 4;
  localparam int unsigned STAT_FULL      = 5;
  localparam int unsigned STAT_LEVEL_LSB = 8;
  localparam int unsigned STAT_PIX_LSB   = 16;

endpackage

// File: rtl/frame_grabber_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign push_ok = push & (~full_c | pop);
  assign pop_ok  = pop & ~empty_c;
  assign dout_c  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/frame_grabber.sv
// VGA frame grabber: captures decimated active pixels into a FIFO, drained over an Avalon-MM slave.
module frame_grabber
  import frame_grabber_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [1:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [PIX_W-1:0] VGA_R,
  input  logic [PIX_W-1:0] VGA_G,
  input  logic [PIX_W-1:0] VGA_B,
  input  logic             HSYNC,
  input  logic             VSYNC,
  output logic             irq
);

  localparam int unsigned DW = 3 * PIX_W;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  state_e           state, state_nx;
  logic             vsync_q;
  logic [CNT_W-1:0] pix_cnt, limit, pix_cnt_inc;
  logic [3:0]       decim, decim_cnt;
  logic             irq_en, ovf, udf;

  logic             ctrl_wr, limit_wr, data_rd;
  logic             arm, abort, ack, arm_go;
  logic             vs_rise, vs_fall, active, push_try, pop, limit_hit;
  logic [DW-1:0]    fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;
  logic [7:0]       level_sat;
  logic [31:0]      status;

  assign ctrl_wr  = chipselect & write & (address == ADDR_CTRL);
  assign limit_wr = chipselect & write & (address == ADDR_LIMIT);
  assign data_rd  = chipselect & read  & (address == ADDR_DATA);
  assign arm      = ctrl_wr & writedata[CTRL_ARM];
  assign abort    = ctrl_wr & writedata[CTRL_ABORT];
  assign ack      = ctrl_wr & writedata[CTRL_ACK];
  assign arm_go   = arm & ~abort & (state == ST_IDLE);

  assign vs_rise     = VSYNC & ~vsync_q;
  assign vs_fall     = ~VSYNC & vsync_q;
  assign active      = (state == ST_CAPTURE) & HSYNC & VSYNC;
  assign push_try    = active & (decim_cnt == 4'd0);
  assign pop         = data_rd & ~fifo_empty;
  assign pix_cnt_inc = pix_cnt + CNT_W'(1);
  // >= so a LIMIT lowered mid-capture still terminates at the next push.
  assign limit_hit   = push_try & (limit != '0) & (pix_cnt_inc >= limit);

  sync_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort),
    .push    (push_try),
    .pop     (pop),
    .din     ({VGA_R, VGA_G, VGA_B}),
    .dout_c  (fifo_dout),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (arm_go)              state_nx = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_rise)             state_nx = ST_CAPTURE;
      ST_CAPTURE: if (limit_hit | vs_fall) state_nx = ST_DONE;
      ST_DONE:    if (ack)                 state_nx = ST_IDLE;
      default:                             state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      vsync_q   <= 1'b1;
      pix_cnt   <= '0;
      limit     <= '0;
      decim     <= '0;
      decim_cnt <= '0;
      irq_en    <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state   <= state_nx;
      vsync_q <= VSYNC;
      if (ctrl_wr) begin
        decim  <= writedata[CTRL_DECIM_LSB +: 4];
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (limit_wr) limit <= CNT_W'(writedata);
      if (abort || arm_go) begin
        pix_cnt   <= '0;
        decim_cnt <= '0;
      end else if (active) begin
        decim_cnt <= (decim_cnt == decim) ? 4'd0 : decim_cnt + 4'd1;
        if (push_try) pix_cnt <= pix_cnt_inc;
      end
      if (arm_go) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (push_try && fifo_full && !pop) ovf <= 1'b1;
        if (data_rd && fifo_empty)         udf <= 1'b1;
      end
      irq <= irq_en & ((state == ST_DONE) | ovf);
    end
  end

  // Register read mux; DATA returns the FIFO head without latency.
  always_comb begin
    level_sat = (32'(fifo_level) > 32'd255) ? 8'hFF : 8'(fifo_level);
    status = '0;
    status[STAT_STATE_LSB +: 2] = state;
    status[STAT_OVF]            = ovf;
    status[STAT_UDF]            = udf;
    status[STAT_EMPTY]          = fifo_empty;
    status[STAT_FULL]           = fifo_full;
    status[STAT_LEVEL_LSB +: 8] = level_sat;
    status[STAT_PIX_LSB +: 16]  = 16'(pix_cnt);
    readdata = '0;
    case (address)
      ADDR_DATA:   if (!fifo_empty) readdata = 32'(fifo_dout);
      ADDR_STATUS: readdata = status;
      ADDR_CTRL: begin
        readdata[CTRL_DECIM_LSB +: 4] = decim;
        readdata[CTRL_IRQ_EN]         = irq_en;
      end
      default:     readdata = 32'(limit);
    endcase
  end

endmodule

// File: tb/tb_frame_grabber.sv
// Directed bench for frame_grabber with a 4-entry FIFO.
module tb_frame_grabber;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect, read, write;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        HSYNC, VSYNC;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  frame_grabber #(.PIX_W(8), .FIFO_DEPTH(4), .CNT_W(20)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; address = 2'd1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; address = 2'd1;
  endtask

  task automatic pix(input logic [23:0] rgb);
    HSYNC = 1'b1;
    {VGA_R, VGA_G, VGA_B} = rgb;
    @(negedge clk);
  endtask

  task automatic frame_start();
    HSYNC = 1'b0; VSYNC = 1'b0;
    @(negedge clk);
    VSYNC = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_end();
    HSYNC = 1'b0; VSYNC = 1'b0;
    @(negedge clk);
    @(negedge clk);
    VSYNC = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 2'd1; writedata = '0; {VGA_R, VGA_G, VGA_B} = '0;
    HSYNC = 1'b0; VSYNC = 1'b1;
    #12;
    n_tests++;
    if (readdata !== 32'h0000_0010) begin n_fail++; $display("FAIL reset_status: got %h exp %h", readdata, 32'h10); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b exp 0", irq); end
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    bus_rd(2'd2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 0", d); end
    bus_rd(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_limit: got %h exp 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_wr(2'd3, 32'h001F_FFFF);
    bus_rd(2'd3, d);
    n_tests++;
    if (d !== 32'h000F_FFFF) begin n_fail++; $display("FAIL limit_rw: got %h exp %h", d, 32'h000F_FFFF); end
    bus_wr(2'd2, 32'h0000_00FF);
    bus_rd(2'd2, d);
    n_tests++;
    if (d !== 32'h0000_00F8) begin n_fail++; $display("FAIL ctrl_rw: got %h exp %h", d, 32'hF8); end
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0000_0010) begin n_fail++; $display("FAIL abort_beats_arm: got %h exp %h", d, 32'h10); end
    bus_wr(2'd2, 32'h0);
  endtask

  task automatic test_limit();
    logic [31:0] d;
    logic [31:0] exp_d;
    bus_wr(2'd3, 32'd4);
    bus_wr(2'd2, 32'h1);
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0000_0011) begin n_fail++; $display("FAIL armed_status: got %h exp %h", d, 32'h11); end
    frame_start();
    for (int p = 1; p <= 6; p++) pix({8'(p), 8'(p + 1), 8'(p + 2)});
    HSYNC = 1'b0;
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0004_0423) begin n_fail++; $display("FAIL limit_status: got %h exp %h", d, 32'h0004_0423); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL limit_irq_off: got %b exp 0", irq); end
    for (int p = 1; p <= 4; p++) begin
      bus_rd(2'd0, d);
      exp_d = {8'h00, 8'(p), 8'(p + 1), 8'(p + 2)};
      n_tests++;
      if (d !== exp_d) begin n_fail++; $display("FAIL limit_data%0d: got %h exp %h", p, d, exp_d); end
    end
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0004_0013) begin n_fail++; $display("FAIL limit_drained: got %h exp %h", d, 32'h0004_0013); end
    frame_end();
    bus_wr(2'd2, 32'h4);
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0004_0010) begin n_fail++; $display("FAIL ack_idle: got %h exp %h", d, 32'h0004_0010); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    bus_wr(2'd3, 32'd0);
    bus_wr(2'd2, 32'h9);
    frame_start();
    for (int p = 0; p < 6; p++) pix({8'h55, 8'h66, 8'(p)});
    HSYNC = 1'b0;
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0006_0426) begin n_fail++; $display("FAIL ovf_status: got %h exp %h", d, 32'h0006_0426); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq: got %b exp 1", irq); end
    frame_end();
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0006_0427) begin n_fail++; $display("FAIL vs_fall_done: got %h exp %h", d, 32'h0006_0427); end
    bus_wr(2'd2, 32'h2);
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0000_0014) begin n_fail++; $display("FAIL ovf_abort: got %h exp %h", d, 32'h14); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b exp 0", irq); end
  endtask

  task automatic test_decim();
    logic [31:0] d;
    logic [31:0] exp_d;
    bus_wr(2'd2, 32'h21);
    frame_start();
    for (int k = 0; k < 9; k++) pix({8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k)});
    HSYNC = 1'b0;
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0003_0302) begin n_fail++; $display("FAIL decim_status: got %h exp %h", d, 32'h0003_0302); end
    for (int k = 0; k < 9; k += 3) begin
      bus_rd(2'd0, d);
      exp_d = {8'h00, 8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k)};
      n_tests++;
      if (d !== exp_d) begin n_fail++; $display("FAIL decim_data%0d: got %h exp %h", k, d, exp_d); end
    end
    frame_end();
    bus_wr(2'd2, 32'h4);
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    bus_rd(2'd0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL udf_data: got %h exp 0", d); end
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0003_0018) begin n_fail++; $display("FAIL udf_status: got %h exp %h", d, 32'h0003_0018); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] exp_d;
    bus_wr(2'd2, 32'h1);
    frame_start();
    for (int q = 1; q <= 4; q++) pix({8'hA0, 8'hB0, 8'(q)});
    HSYNC = 1'b1;
    {VGA_R, VGA_G, VGA_B} = 24'hA0B005;
    bus_rd(2'd0, d);
    HSYNC = 1'b0;
    n_tests++;
    if (d !== 32'h00A0_B001) begin n_fail++; $display("FAIL b2b_head: got %h exp %h", d, 32'h00A0B001); end
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0005_0422) begin n_fail++; $display("FAIL b2b_status: got %h exp %h", d, 32'h0005_0422); end
    for (int q = 2; q <= 5; q++) begin
      bus_rd(2'd0, d);
      exp_d = {8'h00, 8'hA0, 8'hB0, 8'(q)};
      n_tests++;
      if (d !== exp_d) begin n_fail++; $display("FAIL b2b_data%0d: got %h exp %h", q, d, exp_d); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    for (int q = 1; q <= 3; q++) pix({8'hC0, 8'hC0, 8'(q)});
    HSYNC = 1'b0;
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0008_0302) begin n_fail++; $display("FAIL abort_pre: got %h exp %h", d, 32'h0008_0302); end
    bus_wr(2'd2, 32'h2);
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0000_0010) begin n_fail++; $display("FAIL abort_post: got %h exp %h", d, 32'h10); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_wr(2'd2, 32'h9);
    frame_start();
    pix(24'h111111);
    pix(24'h222222);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (readdata !== 32'h0000_0010) begin n_fail++; $display("FAIL rst_mid_status: got %h exp %h", readdata, 32'h10); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq: got %b exp 0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    HSYNC = 1'b0;
    bus_rd(2'd1, d);
    n_tests++;
    if (d !== 32'h0000_0010) begin n_fail++; $display("FAIL rst_release: got %h exp %h", d, 32'h10); end
    bus_rd(2'd2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %h exp 0", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_limit();
    test_overflow();
    test_decim();
    test_underflow();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
